// File: rtl/pool_binary_2x2.sv
// 2x2 binary pooling engine: streams header/row records from the conv SRAM and writes N/2-wide pooled records.
// Define POOL_MAJORITY_EN to pool by 2-of-4 majority instead of the default OR.
module pool_binary_2x2 (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        dut_run,
    output logic        dut_busy,
    output logic [11:0] dut_sram_read_address,
    input  logic [15:0] sram_dut_read_data,
    output logic [11:0] dut_sram_write_address,
    output logic [15:0] dut_sram_write_data,
    output logic        dut_sram_write_enable
);

    typedef enum logic [2:0] {IDLE, HDR, ROW_A, ROW_B, WR, TERM} state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic [11:0] rd_addr_q, rd_addr_d;
    logic [11:0] wr_ptr_q, wr_ptr_d;
    logic [11:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [2:0]  half_q, half_d;
    logic [2:0]  pairs_q, pairs_d;
    logic [15:0] r0_q, r0_d;

    logic [7:0]  pool_bits;
    logic [7:0]  half_mask;
    logic [15:0] pooled_word;
    logic        hdr_valid;

    // r0_q holds the even row; the odd row is on the read bus during ROW_B.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pool
        logic a, b, c, d;
        assign a = r0_q[2*gi];
        assign b = r0_q[2*gi+1];
        assign c = sram_dut_read_data[2*gi];
        assign d = sram_dut_read_data[2*gi+1];
`ifdef POOL_MAJORITY_EN
        assign pool_bits[gi] = (a & b) | (a & c) | (a & d) | (b & c) | (b & d) | (c & d);
`else
        assign pool_bits[gi] = a | b | c | d;
`endif
    end

    assign half_mask   = (8'd1 << half_q) - 8'd1;
    assign pooled_word = {8'h00, pool_bits & half_mask};
    assign hdr_valid   = (sram_dut_read_data == 16'd8) || (sram_dut_read_data == 16'd10) ||
                         (sram_dut_read_data == 16'd14);

    // Read address runs one word ahead of the data bus; it only pauses in ROW_B.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        rd_addr_d = rd_addr_q;
        wr_ptr_d  = wr_ptr_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        half_d    = half_q;
        pairs_d   = pairs_q;
        r0_d      = r0_q;
        case (state_q)
            IDLE: begin
                if (dut_run) begin
                    state_d   = HDR;
                    busy_d    = 1'b1;
                    rd_addr_d = 12'd1;
                    wr_ptr_d  = 12'd0;
                end
            end
            HDR: begin
                we_d     = 1'b1;
                waddr_d  = wr_ptr_q;
                wr_ptr_d = wr_ptr_q + 12'd1;
                if (hdr_valid) begin
                    half_d    = sram_dut_read_data[3:1];
                    pairs_d   = sram_dut_read_data[3:1];
                    wdata_d   = {13'd0, sram_dut_read_data[3:1]};
                    rd_addr_d = rd_addr_q + 12'd1;
                    state_d   = ROW_A;
                end else begin
                    wdata_d = 16'h00FF;
                    state_d = TERM;
                end
            end
            ROW_A: begin
                r0_d      = sram_dut_read_data;
                rd_addr_d = rd_addr_q + 12'd1;
                state_d   = ROW_B;
            end
            ROW_B: begin
                we_d     = 1'b1;
                waddr_d  = wr_ptr_q;
                wdata_d  = pooled_word;
                wr_ptr_d = wr_ptr_q + 12'd1;
                pairs_d  = pairs_q - 3'd1;
                state_d  = WR;
            end
            WR: begin
                rd_addr_d = rd_addr_q + 12'd1;
                state_d   = (pairs_q != 3'd0) ? ROW_A : HDR;
            end
            TERM: begin
                busy_d    = 1'b0;
                rd_addr_d = 12'd0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            rd_addr_q <= 12'd0;
            wr_ptr_q  <= 12'd0;
            waddr_q   <= 12'd0;
            wdata_q   <= 16'd0;
            we_q      <= 1'b0;
            half_q    <= 3'd0;
            pairs_q   <= 3'd0;
            r0_q      <= 16'd0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            rd_addr_q <= rd_addr_d;
            wr_ptr_q  <= wr_ptr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            half_q    <= half_d;
            pairs_q   <= pairs_d;
            r0_q      <= r0_d;
        end
    end

    assign dut_busy               = busy_q;
    assign dut_sram_read_address  = rd_addr_q;
    assign dut_sram_write_address = waddr_q;
    assign dut_sram_write_data    = wdata_q;
    assign dut_sram_write_enable  = we_q;

endmodule

// File: tb/tb_pool_binary_2x2.sv
// Directed testbench for pool_binary_2x2: SRAM model, write monitor and per-scenario checking tasks.
module tb_pool_binary_2x2;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        dut_run = 1'b0;
    logic        dut_busy;
    logic [11:0] dut_sram_read_address;
    logic [15:0] sram_dut_read_data = 16'd0;
    logic [11:0] dut_sram_write_address;
    logic [15:0] dut_sram_write_data;
    logic        dut_sram_write_enable;

    logic [15:0] mem [0:4095];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [11:0] wq_addr [$];
    logic [15:0] wq_data [$];
    int          wq_cyc [$];
    int          fall_cnt = 0;
    int          fall_cyc = 0;
    logic        busy_prev = 1'b0;

    pool_binary_2x2 dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .dut_run                (dut_run),
        .dut_busy               (dut_busy),
        .dut_sram_read_address  (dut_sram_read_address),
        .sram_dut_read_data     (sram_dut_read_data),
        .dut_sram_write_address (dut_sram_write_address),
        .dut_sram_write_data    (dut_sram_write_data),
        .dut_sram_write_enable  (dut_sram_write_enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        sram_dut_read_data <= mem[dut_sram_read_address];
    end

    always @(negedge clk) begin
        if (dut_sram_write_enable) begin
            wq_addr.push_back(dut_sram_write_address);
            wq_data.push_back(dut_sram_write_data);
            wq_cyc.push_back(cyc);
            $display("WRITE cyc=%0d addr=%0d data=0x%04h", cyc, dut_sram_write_address, dut_sram_write_data);
        end
        if (busy_prev && !dut_busy) begin
            fall_cnt = fall_cnt + 1;
            fall_cyc = cyc;
        end
        busy_prev = dut_busy;
    end

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic pulse_run();
        @(negedge clk);
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
    endtask

    task automatic wait_fall(input int start_cnt, output bit ok);
        int n;
        n = 0;
        while (fall_cnt == start_cnt && n < 600) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (fall_cnt != start_cnt);
    endtask

    task automatic load_basic();
        logic [15:0] vin [10] = '{16'h0008, 16'h0081, 16'h0000, 16'h0000, 16'h0000,
                                  16'h0010, 16'h0020, 16'h00FF, 16'h00FF, 16'h00FF};
        foreach (vin[i]) mem[i] = vin[i];
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (dut_busy !== 1'b0 || dut_sram_write_enable !== 1'b0 || dut_sram_read_address !== 12'd0 ||
            dut_sram_write_address !== 12'd0 || dut_sram_write_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b we=%b ra=%0d wa=%0d wd=0x%04h, want all 0",
                     dut_busy, dut_sram_write_enable, dut_sram_read_address, dut_sram_write_address,
                     dut_sram_write_data);
        end
        @(negedge clk);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
`ifdef POOL_MAJORITY_EN
        logic [15:0] vexp [6] = '{16'h0004, 16'h0000, 16'h0000, 16'h0004, 16'h000F, 16'h00FF};
`else
        logic [15:0] vexp [6] = '{16'h0004, 16'h0009, 16'h0000, 16'h0004, 16'h000F, 16'h00FF};
`endif
        int  start;
        bit  ok;
        load_basic();
        clear_log();
        start = fall_cnt;
        pulse_run();
        wait_fall(start, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout busy never fell"); end
        checks++;
        if (wq_data.size() != 6) begin
            errors++;
            $display("FAIL basic_count got %0d writes want 6", wq_data.size());
        end
        for (int i = 0; i < 6 && i < wq_data.size(); i++) begin
            checks++;
            if (wq_addr[i] !== 12'(i) || wq_data[i] !== vexp[i]) begin
                errors++;
                $display("FAIL basic_write%0d got addr=%0d data=0x%04h want addr=%0d data=0x%04h",
                         i, wq_addr[i], wq_data[i], i, vexp[i]);
            end
        end
        for (int i = 2; i < 5 && i < wq_cyc.size(); i++) begin
            checks++;
            if (wq_cyc[i] - wq_cyc[i-1] > 3) begin
                errors++;
                $display("FAIL basic_spacing%0d got %0d cycles want <=3", i, wq_cyc[i] - wq_cyc[i-1]);
            end
        end
        if (wq_cyc.size() > 0) begin
            checks++;
            if (fall_cyc !== wq_cyc[wq_cyc.size()-1] + 1) begin
                errors++;
                $display("FAIL basic_busy_fall got cyc %0d want %0d", fall_cyc, wq_cyc[wq_cyc.size()-1] + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vin [27] = '{16'd14,
                                  16'h3FFF, 16'h0000, 16'hC000, 16'h0000, 16'h0001, 16'h0000,
                                  16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                  16'h0000, 16'h0000,
                                  16'd10,
                                  16'h03FF, 16'h0000, 16'h0C00, 16'h0000, 16'h0200, 16'h0100,
                                  16'h0000, 16'h0004, 16'h0000, 16'h0000,
                                  16'h00FF};
`ifdef POOL_MAJORITY_EN
        logic [15:0] vexp [15] = '{16'h0007, 16'h007F, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                   16'h0000, 16'h0000, 16'h0005, 16'h001F, 16'h0000, 16'h0010,
                                   16'h0000, 16'h0000, 16'h00FF};
`else
        logic [15:0] vexp [15] = '{16'h0007, 16'h007F, 16'h0000, 16'h0001, 16'h0040, 16'h0000,
                                   16'h0000, 16'h0000, 16'h0005, 16'h001F, 16'h0000, 16'h0010,
                                   16'h0002, 16'h0000, 16'h00FF};
`endif
        int start;
        bit ok;
        foreach (vin[i]) mem[i] = vin[i];
        clear_log();
        start = fall_cnt;
        pulse_run();
        wait_fall(start, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout busy never fell"); end
        checks++;
        if (wq_data.size() != 15) begin
            errors++;
            $display("FAIL b2b_count got %0d writes want 15", wq_data.size());
        end
        for (int i = 0; i < 15 && i < wq_data.size(); i++) begin
            checks++;
            if (wq_addr[i] !== 12'(i) || wq_data[i] !== vexp[i]) begin
                errors++;
                $display("FAIL b2b_write%0d got addr=%0d data=0x%04h want addr=%0d data=0x%04h",
                         i, wq_addr[i], wq_data[i], i, vexp[i]);
            end
        end
    endtask

    task automatic test_pool_mode();
        logic [15:0] vin [10] = '{16'h0008, 16'h0001, 16'h0000, 16'h0001, 16'h0002,
                                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00FF};
`ifdef POOL_MAJORITY_EN
        logic [15:0] vexp [6] = '{16'h0004, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h00FF};
`else
        logic [15:0] vexp [6] = '{16'h0004, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h00FF};
`endif
        int start;
        bit ok;
        foreach (vin[i]) mem[i] = vin[i];
        clear_log();
        start = fall_cnt;
        pulse_run();
        wait_fall(start, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mode_timeout busy never fell"); end
        checks++;
        if (wq_data.size() != 6) begin
            errors++;
            $display("FAIL mode_count got %0d writes want 6", wq_data.size());
        end
        for (int i = 0; i < 6 && i < wq_data.size(); i++) begin
            checks++;
            if (wq_addr[i] !== 12'(i) || wq_data[i] !== vexp[i]) begin
                errors++;
                $display("FAIL mode_write%0d got addr=%0d data=0x%04h want addr=%0d data=0x%04h",
                         i, wq_addr[i], wq_data[i], i, vexp[i]);
            end
        end
    endtask

    task automatic test_bad_header();
        logic [15:0] hdrs [2] = '{16'h00FF, 16'h000C};
        int start;
        bit ok;
        foreach (hdrs[h]) begin
            mem[0] = hdrs[h];
            clear_log();
            start = fall_cnt;
            pulse_run();
            wait_fall(start, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL badhdr_timeout hdr=0x%04h busy never fell", hdrs[h]); end
            repeat (3) @(negedge clk);
            #1;
            checks++;
            if (wq_data.size() != 1 || dut_busy !== 1'b0) begin
                errors++;
                $display("FAIL badhdr_count hdr=0x%04h got %0d writes busy=%b want 1 write busy=0",
                         hdrs[h], wq_data.size(), dut_busy);
            end
            if (wq_data.size() > 0) begin
                checks++;
                if (wq_addr[0] !== 12'd0 || wq_data[0] !== 16'h00FF) begin
                    errors++;
                    $display("FAIL badhdr_write hdr=0x%04h got addr=%0d data=0x%04h want addr=0 data=0x00ff",
                             hdrs[h], wq_addr[0], wq_data[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] vexp [6] = '{16'h0004, 16'h0009, 16'h0000, 16'h0004, 16'h000F, 16'h00FF};
        int start;
        bit ok;
`ifdef POOL_MAJORITY_EN
        vexp[1] = 16'h0000;
`endif
        load_basic();
        clear_log();
        pulse_run();
        repeat (4) @(negedge clk);
        #2;
        reset_b = 1'b0;
        #1;
        checks++;
        if (dut_busy !== 1'b0 || dut_sram_write_enable !== 1'b0 || dut_sram_read_address !== 12'd0 ||
            dut_sram_write_address !== 12'd0 || dut_sram_write_data !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b we=%b ra=%0d wa=%0d wd=0x%04h, want all 0",
                     dut_busy, dut_sram_write_enable, dut_sram_read_address, dut_sram_write_address,
                     dut_sram_write_data);
        end
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        clear_log();
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (wq_data.size() != 0 || dut_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_resume got %0d writes busy=%b want 0 writes busy=0", wq_data.size(), dut_busy);
        end
        clear_log();
        start = fall_cnt;
        pulse_run();
        wait_fall(start, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_timeout busy never fell"); end
        checks++;
        if (wq_data.size() != 6) begin
            errors++;
            $display("FAIL midreset_count got %0d writes want 6", wq_data.size());
        end
        for (int i = 0; i < 6 && i < wq_data.size(); i++) begin
            checks++;
            if (wq_addr[i] !== 12'(i) || wq_data[i] !== vexp[i]) begin
                errors++;
                $display("FAIL midreset_write%0d got addr=%0d data=0x%04h want addr=%0d data=0x%04h",
                         i, wq_addr[i], wq_data[i], i, vexp[i]);
            end
        end
    endtask

    task automatic test_run_held();
        logic [15:0] vexp [6] = '{16'h0004, 16'h0009, 16'h0000, 16'h0004, 16'h000F, 16'h00FF};
        int start;
        bit ok;
`ifdef POOL_MAJORITY_EN
        vexp[1] = 16'h0000;
`endif
        load_basic();
        for (int pass = 0; pass < 2; pass++) begin
            clear_log();
            start = fall_cnt;
            if (pass == 0) begin
                @(negedge clk);
                dut_run = 1'b1;
            end
            wait_fall(start, ok);
            if (pass == 1) dut_run = 1'b0;
            checks++;
            if (!ok) begin errors++; $display("FAIL held%0d_timeout busy never fell", pass); end
            checks++;
            if (wq_data.size() != 6) begin
                errors++;
                $display("FAIL held%0d_count got %0d writes want 6", pass, wq_data.size());
            end
            for (int i = 0; i < 6 && i < wq_data.size(); i++) begin
                checks++;
                if (wq_addr[i] !== 12'(i) || wq_data[i] !== vexp[i]) begin
                    errors++;
                    $display("FAIL held%0d_write%0d got addr=%0d data=0x%04h want addr=%0d data=0x%04h",
                             pass, i, wq_addr[i], wq_data[i], i, vexp[i]);
                end
            end
        end
        clear_log();
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (wq_data.size() != 0 || dut_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_release got %0d writes busy=%b want 0 writes busy=0", wq_data.size(), dut_busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h00FF;
        test_reset();
        test_basic();
        test_back_to_back();
        test_pool_mode();
        test_bad_header();
        test_reset_mid();
        test_run_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_binary_2x2.md
POOL_BINARY_2X2 -- requirements
Module: pool_binary_2x2

Interface
REQ-001 The block SHALL expose these ports (name  direction  width  meaning):
REQ-002 clk  input  1  single clock; all state on its rising edge.
REQ-003 reset_b  input  1  reset, asynchronous, active-low.
REQ-004 dut_run  input  1  start request, sampled only in IDLE.
REQ-005 dut_busy  output  1  high from the cycle after accepted start until the cycle after the terminator write.
REQ-006 dut_sram_read_address  output  12  conv-output SRAM read address.
REQ-007 sram_dut_read_data  input  16  read data, valid exactly 1 cycle after its address is presented.
REQ-008 dut_sram_write_address  output  12  pooled-output SRAM write address.
REQ-009 dut_sram_write_data  output  16  pooled-output SRAM write data.
REQ-010 dut_sram_write_enable  output  1  single-cycle write strobe, at most one write per cycle.

Function
REQ-011 The input SRAM SHALL be parsed from address 0 as records: a header word N, then N row words; bit j of a row word is pixel column j.
REQ-012 Valid N SHALL be 8, 10 or 14 (the conv stage's output widths); any other header value, including 0x00FF, SHALL end the run as a terminator.
REQ-013 For each record the block SHALL write header word N/2, then N/2 pooled rows, at contiguous write addresses starting at 0 for each run.
REQ-014 Pooled row k bit j (j < N/2) SHALL be r0[2j] | r0[2j+1] | r1[2j] | r1[2j+1], with r0 = row 2k, r1 = row 2k+1.
REQ-015 Row bits at positions >= N SHALL be ignored; output bits at positions >= N/2 SHALL be 0.
REQ-016 On a terminator header the block SHALL write 0x00FF at the next write address, then return to IDLE.
REQ-017 FSM states SHALL be IDLE, HDR (fetch/decode header), ROW_A, ROW_B (fetch the row pair), WR (write pooled word), TERM (write terminator).
REQ-018 Transitions: IDLE->HDR on dut_run; HDR->ROW_A (valid N) or TERM; ROW_A->ROW_B->WR; WR->ROW_A while pairs remain, else HDR; TERM->IDLE.
REQ-019 Each pooled word SHALL be written no more than 3 cycles after the previous pooled word of the same record.
REQ-020 The read address SHALL advance strictly sequentially (header, rows, next header) and wrap modulo 4096; the write address SHALL also wrap modulo 4096.
REQ-021 dut_run SHALL be ignored while dut_busy is high; a new run after IDLE SHALL restart both read and write addresses at 0.
REQ-022 dut_busy SHALL fall the cycle after the terminator write and remain low until the next accepted dut_run.

Reset
REQ-023 Asserting reset_b low SHALL immediately force IDLE, dut_busy=0, dut_sram_write_enable=0, all addresses 0 and dut_sram_write_data 0, including mid-record.
REQ-024 After reset deassertion no write SHALL occur until a new dut_run is accepted; the interrupted run SHALL NOT resume.

Configuration
REQ-025 With macro POOL_MAJORITY_EN defined, pooled bit j SHALL be 1 iff at least 2 of the 4 window bits are 1; without it, REQ-014 (OR pooling) applies. All other behaviour SHALL be identical.

Verification
REQ-026 Input {0x0008, 0x0081,0x0000, 0x0000,0x0000, 0x0010,0x0020, 0x00FF,0x00FF, 0x00FF} -> writes addr0..5 = 0x0004,0x0009,0x0000,0x0004,0x000F,0x00FF; dut_busy falls the cycle after addr5 is written.
REQ-027 Back-to-back records N=14 then N=10, then terminator -> headers 0x0007 at addr0 and 0x0005 at addr8, terminator 0x00FF at addr14, no address gaps.
REQ-028 N=8 record with first pair 0x0001,0x0000 -> first pooled word 0x0001 without POOL_MAJORITY_EN, 0x0000 with it; pair 0x0001,0x0002 -> 0x0001 in both builds.
REQ-029 First header 0x00FF, and separately first header 0x000C -> single write 0x00FF at addr0; FSM returns to IDLE.
REQ-030 reset_b pulsed low mid-record, then dut_run -> outputs 0 during reset; the rerun produces a write sequence identical to an uninterrupted run.
REQ-031 dut_run held high throughout a run -> start ignored while busy; a new run begins only after dut_busy falls, with write address restarting at 0.
